// File: rtl/vga_fb_blitter.sv
// rtl/vga_fb_blitter.sv - Wishbone initiator that fills clipped rectangles through the VGA register window
module vga_fb_blitter #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        clipped
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WE0   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_ADDR  = 3'd4;
    localparam logic [2:0] S_WE1   = 3'd5;
    localparam logic [2:0] S_WE0P  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int          CW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [10:0] H_END = 11'(H_RES);
    localparam logic [10:0] V_END = 11'(V_RES);

    logic [2:0]    state;
    logic [9:0]    x_r, y_r, w_r, h_r;
    logic [7:0]    color_r;
    logic [10:0]   x_end, y_end;
    logic [9:0]    col, row;
    logic [18:0]   row_base;
    logic [CW-1:0] ack_cnt;
    logic          cyc_r;
    logic [31:0]   adr_r, dat_r;
    logic [3:0]    sel_r;
    logic          err_r, clip_r;

    logic [10:0] sum_x, sum_y;
    logic        off_screen, zero_dim, x_red, y_red;
    logic [18:0] pix;
    logic        last_col, last_row;
    logic [31:0] t_adr, t_dat;
    logic [3:0]  t_sel;

    // 11-bit sums so x+w and y+h never wrap before clipping
    assign sum_x      = {1'b0, x_r} + {1'b0, w_r};
    assign sum_y      = {1'b0, y_r} + {1'b0, h_r};
    assign off_screen = ({1'b0, x_r} >= H_END) || ({1'b0, y_r} >= V_END);
    assign zero_dim   = (w_r == 10'd0) || (h_r == 10'd0);
    assign x_red      = sum_x > H_END;
    assign y_red      = sum_y > V_END;
    assign pix        = row_base + 19'(col);
    assign last_col   = ({1'b0, col} + 11'd1) == x_end;
    assign last_row   = ({1'b0, row} + 11'd1) == y_end;

    always_comb begin
        t_adr = BASE_ADDR + 32'h4;
        t_dat = 32'd0;
        t_sel = 4'b0001;
        case (state)
            S_DATA: begin
                t_adr = BASE_ADDR + 32'hC;
                t_dat = {24'd0, color_r};
            end
            S_ADDR: begin
                t_adr = BASE_ADDR + 32'h8;
                t_dat = {13'd0, pix};
                t_sel = 4'b0111;
            end
            S_WE1:   t_dat = 32'd1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            x_r      <= '0;
            y_r      <= '0;
            w_r      <= '0;
            h_r      <= '0;
            color_r  <= '0;
            x_end    <= '0;
            y_end    <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            ack_cnt  <= '0;
            cyc_r    <= 1'b0;
            adr_r    <= '0;
            dat_r    <= '0;
            sel_r    <= '0;
            err_r    <= 1'b0;
            clip_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_r  <= 1'b0;
                    clip_r <= 1'b0;
                    if (cmd_valid) begin
                        x_r     <= cmd_x;
                        y_r     <= cmd_y;
                        w_r     <= cmd_w;
                        h_r     <= cmd_h;
                        color_r <= cmd_color;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    x_end    <= x_red ? H_END : sum_x;
                    y_end    <= y_red ? V_END : sum_y;
                    col      <= x_r;
                    row      <= y_r;
                    row_base <= 19'(y_r * H_RES);
                    // A zero-size command that lies on screen is empty, not clipped
                    clip_r   <= off_screen || (!zero_dim && (x_red || y_red));
                    state    <= (off_screen || zero_dim) ? S_DONE : S_WE0;
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    // A transaction starts when the bus is idle in a transfer state
                    if (!cyc_r) begin
                        cyc_r   <= 1'b1;
                        adr_r   <= t_adr;
                        dat_r   <= t_dat;
                        sel_r   <= t_sel;
                        ack_cnt <= '0;
                    end else if (wb_ack_i) begin
                        cyc_r <= 1'b0;
                        case (state)
                            S_WE0:  state <= S_DATA;
                            S_DATA: state <= S_ADDR;
                            S_ADDR: state <= S_WE1;
                            S_WE1:  state <= S_WE0P;
                            default: begin
                                if (last_col) begin
                                    if (last_row) begin
                                        state <= S_DONE;
                                    end else begin
                                        col      <= x_r;
                                        row      <= row + 10'd1;
                                        row_base <= row_base + 19'(H_RES);
                                        state    <= S_ADDR;
                                    end
                                end else begin
                                    col   <= col + 10'd1;
                                    state <= S_ADDR;
                                end
                            end
                        endcase
                    end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        cyc_r <= 1'b0;
                        err_r <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = done && err_r;
    assign clipped   = done && clip_r;
    assign wb_cyc_o  = cyc_r;
    assign wb_stb_o  = cyc_r;
    assign wb_we_o   = cyc_r;
    assign wb_adr_o  = adr_r;
    assign wb_dat_o  = dat_r;
    assign wb_sel_o  = sel_r;

endmodule

// File: tb/tb_vga_fb_blitter.sv
// tb/tb_vga_fb_blitter.sv - table-driven and randomized bench for vga_fb_blitter against a raster-order model
module tb_vga_fb_blitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [7:0]  cmd_color;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        busy, done, err, clipped;

    always #5 clk = ~clk;

    vga_fb_blitter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_ack_i (wb_ack_i),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .clipped  (clipped)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          gap;
    } txn_t;

    typedef struct {
        int          x, y, w, h;
        logic [7:0]  color;
        int          delay;
        int          exp_n;
        bit          exp_clip;
    } vec_t;

    txn_t txq[$];
    txn_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    int          ack_delay = 0;
    bit          ack_never = 1'b0;
    int          stb_cnt = 0, idle_cnt = 0, last_len = 0;
    int          we_bad = 0, unstable = 0;
    logic [31:0] cur_adr, cur_dat;
    logic [3:0]  cur_sel;
    int          cur_gap;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Slave model: acks after ack_delay stb cycles and logs every acknowledged write
    always @(negedge clk) begin
        if (rst) begin
            wb_ack_i = 1'b0;
            stb_cnt  = 0;
        end else begin
            if ((wb_cyc_o != wb_stb_o) || (wb_we_o != wb_stb_o)) we_bad++;
            if (wb_stb_o) begin
                if (stb_cnt == 0) begin
                    cur_adr  = wb_adr_o;
                    cur_dat  = wb_dat_o;
                    cur_sel  = wb_sel_o;
                    cur_gap  = idle_cnt;
                    idle_cnt = 0;
                end else if (wb_adr_o != cur_adr || wb_dat_o != cur_dat || wb_sel_o != cur_sel) begin
                    unstable++;
                end
                if (!ack_never && stb_cnt >= ack_delay && !wb_ack_i) begin
                    wb_ack_i = 1'b1;
                    txq.push_back('{cur_adr, cur_dat, cur_sel, cur_gap});
                end
                stb_cnt++;
            end else begin
                if (stb_cnt > 0) last_len = stb_cnt;
                wb_ack_i = 1'b0;
                stb_cnt  = 0;
                idle_cnt++;
            end
        end
    end

    function automatic void push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{a, d, s, 0});
    endfunction

    // Reference: clip with plain min(), then enumerate pixels row by row with y*640+x
    function automatic bit model(input int x, input int y, input int w, input int h, input logic [7:0] c);
        int  xe, ye;
        bit  zero, off;
        exp_q.delete();
        zero = (w == 0) || (h == 0);
        off  = (x >= 640) || (y >= 480);
        xe   = (x + w < 640) ? x + w : 640;
        ye   = (y + h < 480) ? y + h : 480;
        if (!zero && !off) begin
            push_exp(32'h4, 32'd0, 4'b0001);
            push_exp(32'hC, {24'd0, c}, 4'b0001);
            for (int r = y; r < ye; r++) begin
                for (int cc = x; cc < xe; cc++) begin
                    push_exp(32'h8, 32'(r * 640 + cc), 4'b0111);
                    push_exp(32'h4, 32'd1, 4'b0001);
                    push_exp(32'h4, 32'd0, 4'b0001);
                end
            end
        end
        return off || (!zero && (x + w > 640 || y + h > 480));
    endfunction

    task automatic start_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c);
        @(negedge clk);
        txq.delete();
        idle_cnt  = 0;
        we_bad    = 0;
        unstable  = 0;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c,
                           output bit got_done, output bit got_clip, output bit got_err);
        start_cmd(x, y, w, h, c);
        got_done = 1'b0;
        got_clip = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                got_done = 1'b1;
                got_clip = clipped;
                got_err  = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic cmd_and_check(input string name, input int x, input int y, input int w, input int h,
                                 input logic [7:0] c, output int n_txn, output bit got_clip);
        bit got_done, got_err, exp_clip;
        int bad, gbad;
        run_cmd(x, y, w, h, c, got_done, got_clip, got_err);
        exp_clip = model(x, y, w, h, c);
        n_txn = txq.size();
        check({name, ".done"}, got_done, 1);
        check({name, ".clipped"}, got_clip, exp_clip);
        check({name, ".err"}, got_err, 0);
        check({name, ".txn_count"}, txq.size(), exp_q.size());
        bad = 0;
        gbad = 0;
        for (int i = 0; i < txq.size() && i < exp_q.size(); i++) begin
            if (bad == 0 && (txq[i].adr != exp_q[i].adr || txq[i].dat != exp_q[i].dat || txq[i].sel != exp_q[i].sel))
                bad = i + 1;
            if (i > 0 && txq[i].gap != 1) gbad++;
        end
        check({name, ".first_bad_txn"}, bad, 0);
        check({name, ".idle_gaps"}, gbad, 0);
        check({name, ".protocol"}, we_bad + unstable, 0);
        @(negedge clk);
        check({name, ".ready_after"}, {cmd_ready, busy, done}, 3'b100);
    endtask

    vec_t vecs[6];
    int   n_txn, seen, found;
    bit   gclip, gdone, gerr;

    initial begin
        vecs[0] = '{0, 0, 2, 2, 8'h5A, 0, 14, 1'b0};
        vecs[1] = '{638, 478, 4, 4, 8'hA5, 0, 14, 1'b1};
        vecs[2] = '{0, 0, 0, 3, 8'h11, 0, 0, 1'b0};
        vecs[3] = '{700, 10, 2, 2, 8'h22, 0, 0, 1'b1};
        vecs[4] = '{100, 200, 2, 1, 8'h3C, 5, 8, 1'b0};
        vecs[5] = '{5, 500, 0, 2, 8'h44, 1, 0, 1'b1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        repeat (3) @(negedge clk);
        check("reset_bus_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
        check("reset_adr_dat", {wb_adr_o, wb_dat_o}, 0);
        check("reset_status", {cmd_ready, busy, done, err, clipped}, 5'b10000);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb_cyc_o || wb_stb_o || wb_we_o) seen++;
        end
        check("idle_no_bus", seen, 0);

        foreach (vecs[i]) begin
            ack_delay = vecs[i].delay;
            cmd_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                          vecs[i].color, n_txn, gclip);
            check($sformatf("vec%0d.table_count", i), n_txn, vecs[i].exp_n);
            check($sformatf("vec%0d.table_clip", i), gclip, vecs[i].exp_clip);
        end

        // Slave never acks: the first write must time out after 255 strobe cycles
        ack_delay = 0;
        ack_never = 1'b1;
        run_cmd(5, 5, 2, 2, 8'h77, gdone, gclip, gerr);
        check("timeout.done", gdone, 1);
        check("timeout.err", gerr, 1);
        check("timeout.clipped", gclip, 0);
        check("timeout.acked_txns", txq.size(), 0);
        @(negedge clk);
        check("timeout.ready_next", {cmd_ready, done, wb_stb_o}, 3'b100);
        check("timeout.stb_len", last_len, 255);
        ack_never = 1'b0;

        // Reset while a WE1 write is stalled on a slow slave
        ack_delay = 5;
        start_cmd(10, 10, 3, 3, 8'h99);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            if (wb_stb_o && wb_adr_o == 32'h4 && wb_dat_o == 32'd1) found = 1;
            else @(negedge clk);
        end
        check("rst_mid.found_we1", found, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.bus_dropped", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        check("rst_mid.status", {cmd_ready, busy}, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 1;
        cmd_and_check("after_rst", 1, 2, 2, 1, 8'hC3, n_txn, gclip);

        for (int k = 0; k < 30; k++) begin
            int x, y, w, h;
            x = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 639) : $urandom_range(630, 700);
            y = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 479) : $urandom_range(470, 500);
            w = $urandom_range(0, 4);
            h = $urandom_range(0, 4);
            ack_delay = $urandom_range(0, 2);
            cmd_and_check($sformatf("rand%0d", k), x, y, w, h, 8'($urandom), n_txn, gclip);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_fb_blitter.md
Name: vga_fb_blitter

Overview:
- Wishbone initiator that fills rectangles in the VGA framebuffer.
- Drives the VGA peripheral's register window: write-enable at 0x04, pixel address at 0x08, pixel data at 0x0C.
- Accepts one fill command (x, y, w, h, colour) over a valid/ready handshake, clips it to the screen, and issues the register-write sequence for every pixel in raster order.
- Sits between a command source (CPU-side register block or game logic) and the VGA peripheral's slave port on the same Wishbone clock.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the VGA peripheral register window.
- H_RES, 640, visible columns; also the row stride of the linear pixel address.
- V_RES, 480, visible rows.
- ACK_TIMEOUT, 255, cycles to wait for wb_ack_i before aborting.

Ports:
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  10  left column.
- cmd_y  in  10  top row.
- cmd_w  in  10  width in pixels.
- cmd_h  in  10  height in pixels.
- cmd_color  in  8  pixel value {b[1:0], g[2:0], r[2:0]}.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command end.
- err  out  1  one-cycle pulse with done on ack timeout.
- clipped  out  1  one-cycle pulse with done when the rectangle was reduced or dropped.

Behaviour:
- Reset (asynchronous, any state):
  - All Wishbone outputs, busy, done, err and clipped go to 0.
  - cmd_ready goes to 1 and the FSM returns to IDLE.
  - An in-flight transaction is abandoned.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on cmd_valid & cmd_ready; all cmd_* fields are registered on that edge.
  - busy=1 from the next cycle until the done cycle, inclusive.
- Clipping in SETUP (1 cycle):
  - x_end = min(x+w, H_RES) and y_end = min(y+h, V_RES), computed 11 bits wide with no wrap.
  - If w==0, h==0, x>=H_RES or y>=V_RES: no bus traffic, go straight to DONE. clipped=1 unless the drop was only because w==0 or h==0.
  - clipped=1 whenever x_end or y_end was reduced.
- Bus transaction rules:
  - wb_cyc_o, wb_stb_o and wb_we_o rise and fall together.
  - wb_adr_o, wb_dat_o and wb_sel_o are stable for the whole transaction.
  - The transaction ends on the cycle after wb_ack_i is sampled high: cyc/stb/we are deasserted.
  - Exactly one idle cycle (we=0) follows every transaction.
  - wb_we_o is never high outside a transaction, because the slave latches on we alone.
  - The block only writes; wb_dat_i is not needed.
- Transaction encodings:
  - WE0: adr BASE+0x04, dat 0, sel 0001.
  - WE1: adr BASE+0x04, dat 1, sel 0001.
  - DATA: adr BASE+0x0C, dat {24'b0, colour}, sel 0001.
  - ADDR: adr BASE+0x08, dat {13'b0, pix[18:0]}, sel 0111.
- FSM sequence:
  - IDLE → SETUP → WE0 → DATA.
  - Then per pixel: ADDR → WE1 → WE0.
  - After the last pixel → DONE → IDLE.
  - DONE lasts 1 cycle with done=1.
- Address arithmetic (no multiplier):
  - row_base is a 19-bit register initialised to y*H_RES, computed incrementally or with a constant multiply in SETUP.
  - pix = row_base + col.
  - col increments from x; when it reaches x_end, col resets to x, row_base += H_RES and row increments.
  - The last pixel is (x_end-1, y_end-1).
  - Pixel order is row-major.
- Per-command bus traffic: total transactions = 2 + 3·W'·H', where W' and H' are the clipped dimensions.
- Timeout:
  - An ack counter restarts at each transaction start.
  - If it reaches ACK_TIMEOUT with no ack: drop cyc/stb/we, skip the remaining pixels, and enter DONE with err=1.
  - WE0 is not retried; the command source must reissue.
- wb_ack_i outside a transaction is ignored.
- cmd_valid during busy is ignored; it is not queued.

Test Plan:
- Reset then idle: wb_rst_i pulse → all outputs 0, cmd_ready=1; no cyc/stb/we over 20 cycles.
- 2×2 fill at (0,0), colour 0x5A, ideal slave (ack 1 cycle after stb): 14 transactions, namely WE0, DATA(0x5A), then ADDR/WE1/WE0 for pix 0, 1, 640, 641. Expect done=1, clipped=0, err=0, and wb_we_o never high outside stb.
- Clip: (638,478), w=4, h=4 → only pix 306558, 306559, 307198, 307199 written (14 transactions); clipped=1 with done.
- Degenerate commands: w=0 → done after SETUP, zero transactions, clipped=0. x=700 → zero transactions, clipped=1.
- Timeout: slave never acks → stb held 255 cycles then dropped; done=1 and err=1 in the same cycle; cmd_ready=1 on the next cycle.
- Stall and reset: slave delays ack by 5 cycles → adr/dat/sel held stable throughout. Then assert wb_rst_i during a WE1 transaction → cyc/stb/we drop immediately (asynchronously); the next command completes normally.
